// File: rtl/apb_master_bridge.sv
// Single-outstanding command-to-APB bridge: one command in, one APB transfer out,
// one response back. Misaligned commands and unresponsive completers yield error responses.
module apb_master_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        pclk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] paddr_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  localparam int CW = 8;
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          rsp_timeout_q, rsp_timeout_d;

  always_comb begin
    // NOTE: every signal gets a hold-value default before the case so no path leaves one unassigned (no latches).
    state_d       = state_q;
    cnt_d         = cnt_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          write_d = cmd_write_i;
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          cnt_d   = '0;
          if (cmd_addr_i[1:0] != 2'b00) begin
            // Misaligned: answer directly without touching the bus.
            state_d       = RESP;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
            rsp_rdata_d   = '0;
          end else begin
            state_d = SETUP;
          end
        end
      end

      SETUP: begin
        state_d = ACCESS;
        cnt_d   = CW'(1);
      end

      ACCESS: begin
        // cnt_q is the 1-based index of the current ACCESS cycle; pready wins over timeout.
        if (pready_i) begin
          state_d       = RESP;
          rsp_err_d     = pslverr_i;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = write_q ? '0 : prdata_i;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d       = RESP;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready_o   = (state_q == IDLE);
  assign psel_o        = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o     = (state_q == ACCESS);
  assign pwrite_o      = write_q;
  assign paddr_o       = addr_q;
  assign pwdata_o      = wdata_q;
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: latency, wait states, slave error, timeout,
// misaligned commands, response back-pressure and mid-transfer reset.
module tb_apb_master_bridge;

  logic        pclk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] paddr_o, pwdata_o, prdata_i;
  logic        pready_i, pslverr_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o, rsp_timeout_o;

  int n_checks = 0;
  int n_pass   = 0;

  apb_master_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .pclk_i(pclk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o)
  );

  always #5 pclk_i = ~pclk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge pclk_i);
    #1;
  endtask

  // Presents a command for one edge, then scrambles the payload lines.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    tick();
    cmd_valid_i = 1'b0;
    cmd_write_i = ~wr;
    cmd_addr_i  = 32'hDEAD_BEE0;
    cmd_wdata_i = 32'h5A5A_5A5A;
  endtask

  // Plays the completer; index 1 is the first sample after the accepting edge.
  // pready_at = 0 means the completer never answers.
  task automatic run_apb(input int pready_at, input logic [31:0] rdata_val, input logic slverr_val,
                         output int first_psel, output int first_pen, output int rsp_at,
                         output int n_access, output logic stable);
    logic [31:0] a0, w0;
    logic        wr0;
    first_psel = 0; first_pen = 0; rsp_at = 0; n_access = 0; stable = 1'b1;
    a0 = '0; w0 = '0; wr0 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (rsp_valid_o) begin
        rsp_at = i;
        break;
      end
      if (psel_o) begin
        if (first_psel == 0) begin
          first_psel = i; a0 = paddr_o; w0 = pwdata_o; wr0 = pwrite_o;
        end else if (paddr_o !== a0 || pwdata_o !== w0 || pwrite_o !== wr0) begin
          stable = 1'b0;
        end
      end
      if (penable_o && first_pen == 0) first_pen = i;
      if (psel_o && penable_o) begin
        n_access++;
        if (n_access == pready_at) begin
          pready_i = 1'b1; prdata_i = rdata_val; pslverr_i = slverr_val;
        end else begin
          pready_i = 1'b0; prdata_i = 32'hBAD0_0000 | n_access; pslverr_i = 1'b1;
        end
      end else begin
        pready_i = 1'b0; prdata_i = 32'hFFFF_FFFF; pslverr_i = 1'b1;
      end
      tick();
    end
    pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = '0;
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check({tag, "_rsp_drop"}, rsp_valid_o, 1'b0);
    check({tag, "_ready_back"}, cmd_ready_o, 1'b1);
  endtask

  int          fp, fe, ra, na;
  logic        st;
  logic        hold_ok;
  logic [31:0] snap_rdata;
  logic        snap_err, snap_to;

  initial begin
    rst_i = 1'b1; cmd_valid_i = 0; cmd_write_i = 0; cmd_addr_i = '0; cmd_wdata_i = '0;
    prdata_i = '0; pready_i = 0; pslverr_i = 0; rsp_ready_i = 0;
    #3;
    check("rst_psel", psel_o, 0);
    check("rst_penable", penable_o, 0);
    check("rst_pwrite", pwrite_o, 0);
    check("rst_paddr", paddr_o, 0);
    check("rst_pwdata", pwdata_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_rdata", rsp_rdata_o, 0);
    check("rst_rsp_err", rsp_err_o, 0);
    check("rst_rsp_timeout", rsp_timeout_o, 0);
    repeat (2) @(posedge pclk_i);
    @(negedge pclk_i) rst_i = 1'b0;
    tick();
    check("post_rst_cmd_ready", cmd_ready_o, 1);

    // Zero-wait write: psel N+1, penable N+2, response N+3, rdata forced to 0.
    issue(1'b1, 32'h4, 32'hA5);
    check("zw_paddr", paddr_o, 32'h4);
    check("zw_pwdata", pwdata_o, 32'hA5);
    check("zw_pwrite", pwrite_o, 1);
    check("zw_cmd_ready_busy", cmd_ready_o, 0);
    run_apb(1, 32'h1234_5678, 1'b0, fp, fe, ra, na, st);
    check("zw_psel_cycle", fp, 1);
    check("zw_penable_cycle", fe, 2);
    check("zw_rsp_cycle", ra, 3);
    check("zw_err", rsp_err_o, 0);
    check("zw_timeout", rsp_timeout_o, 0);
    check("zw_rdata", rsp_rdata_o, 0);
    finish_rsp("zw");

    // Three-wait read: completes on the 4th ACCESS cycle.
    issue(1'b0, 32'h0, 32'h0);
    run_apb(4, 32'h0000_000F, 1'b0, fp, fe, ra, na, st);
    check("rd3_access_cycles", na, 4);
    check("rd3_rsp_cycle", ra, 6);
    check("rd3_stable", st, 1);
    check("rd3_rdata", rsp_rdata_o, 32'h0000_000F);
    check("rd3_err", rsp_err_o, 0);
    finish_rsp("rd3");

    // Slave error on write.
    issue(1'b1, 32'h100, 32'hCAFE_0001);
    run_apb(1, 32'hFFFF_0000, 1'b1, fp, fe, ra, na, st);
    check("serr_err", rsp_err_o, 1);
    check("serr_timeout", rsp_timeout_o, 0);
    check("serr_rdata", rsp_rdata_o, 0);
    finish_rsp("serr");

    // Timeout: completer never answers.
    issue(1'b0, 32'h200, 32'h0);
    run_apb(0, 32'h0, 1'b0, fp, fe, ra, na, st);
    check("to_access_cycles", na, 16);
    check("to_rsp_cycle", ra, 18);
    check("to_err", rsp_err_o, 1);
    check("to_timeout", rsp_timeout_o, 1);
    check("to_rdata", rsp_rdata_o, 0);
    finish_rsp("to");

    // pready on the 16th cycle wins over timeout.
    issue(1'b0, 32'h204, 32'h0);
    run_apb(16, 32'h1357_9BDF, 1'b0, fp, fe, ra, na, st);
    check("to16_access_cycles", na, 16);
    check("to16_err", rsp_err_o, 0);
    check("to16_timeout", rsp_timeout_o, 0);
    check("to16_rdata", rsp_rdata_o, 32'h1357_9BDF);
    finish_rsp("to16");

    // Misaligned: no bus activity, immediate error, then back-pressure hold.
    issue(1'b0, 32'h6, 32'h0);
    run_apb(1, 32'h7777_7777, 1'b0, fp, fe, ra, na, st);
    check("mis_psel_never", fp, 0);
    check("mis_rsp_cycle", ra, 1);
    check("mis_err", rsp_err_o, 1);
    check("mis_timeout", rsp_timeout_o, 0);
    check("mis_rdata", rsp_rdata_o, 0);
    snap_rdata = rsp_rdata_o; snap_err = rsp_err_o; snap_to = rsp_timeout_o;
    hold_ok = 1'b1;
    cmd_valid_i = 1'b1; cmd_addr_i = 32'h40;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!rsp_valid_o || cmd_ready_o || psel_o || rsp_rdata_o !== snap_rdata ||
          rsp_err_o !== snap_err || rsp_timeout_o !== snap_to) hold_ok = 1'b0;
    end
    cmd_valid_i = 1'b0;
    check("mis_hold_stable", hold_ok, 1);
    finish_rsp("mis");

    // Reset during ACCESS: outputs drop asynchronously, no response afterwards.
    issue(1'b0, 32'h10, 32'h0);
    pready_i = 1'b0;
    tick();
    tick();
    check("rmid_in_access", penable_o, 1);
    #2 rst_i = 1'b1;
    #1;
    check("rmid_psel", psel_o, 0);
    check("rmid_penable", penable_o, 0);
    check("rmid_rsp_valid", rsp_valid_o, 0);
    repeat (2) @(posedge pclk_i);
    @(negedge pclk_i) rst_i = 1'b0;
    tick();
    check("rmid_cmd_ready", cmd_ready_o, 1);
    repeat (3) tick();
    check("rmid_no_rsp", rsp_valid_o, 0);

    // Recovery: a normal write still completes.
    issue(1'b1, 32'h8, 32'h1);
    run_apb(1, 32'h0, 1'b0, fp, fe, ra, na, st);
    check("rec_rsp_cycle", ra, 3);
    check("rec_err", rsp_err_o, 0);
    finish_rsp("rec");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: max ACCESS-phase cycles waited for pready_i (legal 2..255).
REQ-002 SHALL have port pclk_i, input, 1: single clock; all logic on rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have ports cmd_valid_i in 1 / cmd_ready_o out 1: command handshake.
REQ-005 SHALL have ports cmd_write_i in 1, cmd_addr_i in 32, cmd_wdata_i in 32: command payload (1 = write).
REQ-006 SHALL have ports psel_o out 1, penable_o out 1, pwrite_o out 1, paddr_o out 32, pwdata_o out 32: APB request.
REQ-007 SHALL have ports prdata_i in 32, pready_i in 1, pslverr_i in 1: APB completer response.
REQ-008 SHALL have ports rsp_valid_o out 1 / rsp_ready_i in 1: response handshake.
REQ-009 SHALL have ports rsp_rdata_o out 32, rsp_err_o out 1, rsp_timeout_o out 1: response payload.

Function
REQ-010 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-011 SHALL assert cmd_ready_o only in IDLE; command accepted on a cycle with cmd_valid_i=1 and cmd_ready_o=1.
REQ-012 SHALL register cmd_write_i/cmd_addr_i/cmd_wdata_i at acceptance; payload need not be held by the source afterwards.
REQ-013 SHALL, on acceptance with cmd_addr_i[1:0]=0, move IDLE->SETUP.
REQ-014 SHALL, on acceptance with cmd_addr_i[1:0]!=0 (misaligned), skip APB (psel_o stays 0), go IDLE->RESP with rsp_err_o=1, rsp_timeout_o=0, rsp_rdata_o=0.
REQ-015 SHALL drive in SETUP: psel_o=1, penable_o=0, pwrite_o/paddr_o/pwdata_o = registered payload; SETUP lasts exactly one cycle, then ACCESS.
REQ-016 SHALL drive in ACCESS: psel_o=1, penable_o=1, pwrite_o/paddr_o/pwdata_o unchanged from SETUP.
REQ-017 SHALL sample pslverr_i and prdata_i only in ACCESS with pready_i=1; values on other cycles ignored.
REQ-018 SHALL, on ACCESS with pready_i=1, go to RESP next cycle: rsp_err_o=pslverr_i, rsp_timeout_o=0, rsp_rdata_o=prdata_i for reads, 0 for writes.
REQ-019 SHALL count ACCESS cycles from 1; if count reaches TIMEOUT_CYCLES with pready_i=0 on that cycle, go to RESP: rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
REQ-020 SHALL treat pready_i=1 on the TIMEOUT_CYCLES-th ACCESS cycle as normal completion (pready wins over timeout).
REQ-021 SHALL drive psel_o=0 and penable_o=0 in IDLE and RESP; pwrite_o/paddr_o/pwdata_o are don't-care while psel_o=0.
REQ-022 SHALL assert rsp_valid_o only in RESP; payload stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-023 SHALL go RESP->IDLE on rsp_valid_o=1 and rsp_ready_i=1; next command acceptable in the following cycle.
REQ-024 SHALL give zero-wait latency: accept at cycle N, psel_o=1 at N+1, penable_o=1 at N+2, pready_i=1 at N+2 -> rsp_valid_o=1 at N+3.
REQ-025 SHALL process one transaction at a time; no command buffering or pipelining.
REQ-026 SHALL clear the ACCESS counter on every entry to SETUP.

Reset
REQ-027 SHALL, while rst_i=1 (asynchronously), force state IDLE, counter 0, psel_o=0, penable_o=0, pwrite_o=0, paddr_o=0, pwdata_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, rsp_timeout_o=0.
REQ-028 SHALL assert cmd_ready_o=1 on the first clock edge after rst_i deasserts.
REQ-029 SHALL abandon an in-flight transaction on mid-operation reset, with no response generated for it.

Verification
REQ-030 SHALL cover zero-wait write: addr 0x4, wdata 0xA5, pready_i=1 first ACCESS cycle -> psel N+1, penable N+2, rsp_valid N+3, err=0, rdata=0.
REQ-031 SHALL cover 3-wait read: addr 0x0, pready_i=1 on 4th ACCESS cycle with prdata_i=0x0000000F -> rsp_rdata_o=0x0000000F, err=0, address/control stable throughout.
REQ-032 SHALL cover slave error: write with pready_i=1, pslverr_i=1 -> rsp_err_o=1, rsp_timeout_o=0.
REQ-033 SHALL cover timeout: pready_i held 0, TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles, then rsp_err_o=1, rsp_timeout_o=1; also pready_i=1 on 16th cycle -> normal completion.
REQ-034 SHALL cover misaligned addr 0x6 -> psel_o never 1, rsp_valid_o at N+1 with err=1; plus rsp_ready_i held 0 for 5 cycles -> payload stable, cmd_ready_o=0.
REQ-035 SHALL cover rst_i pulse during ACCESS -> psel_o/penable_o/rsp_valid_o=0 immediately, cmd_ready_o=1 after release.
